// File: rtl/strike_scheduler.sv
// strike_scheduler: round-robin strike arbiter with per-program
// prescaled strike counters and an evict handshake.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   strike_req[N]     per-program strike request (level)
//   strike_gnt[N]     one-hot single-cycle grant
//   clear_req[N]      per-program clear pulse (program re-placed)
//   evict_valid/id    eviction request to the placement engine
//   evict_ready       placement engine accepts the eviction
//   busy              scheduler not idle
//   strike_count_all  concatenated counts (only with STRIKE_STATUS_EN)
//
// Optional feature: define STRIKE_STATUS_EN to add strike_count_all.
module strike_scheduler #(
    parameter int NUM_PROG     = 4,
    parameter int PRESCALE     = 4,
    parameter int CNT_W        = 4,
    parameter int STRIKE_LIMIT = 8,
    parameter int ID_W         = $clog2(NUM_PROG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_PROG-1:0] strike_req,
    output logic [NUM_PROG-1:0] strike_gnt,
    input  logic [NUM_PROG-1:0] clear_req,
    output logic                evict_valid,
    output logic [ID_W-1:0]     evict_id,
    input  logic                evict_ready,
    output logic                busy
`ifdef STRIKE_STATUS_EN
    ,
    output logic [NUM_PROG*CNT_W-1:0] strike_count_all
`endif
);

    localparam int PRE_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STRIKE_LIMIT);
    localparam logic [ID_W:0]    NP      = (ID_W+1)'(NUM_PROG);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_PROG - 1);

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        EVICT
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     win;
    logic [PRE_W-1:0]    pre [NUM_PROG];
    logic [CNT_W-1:0]    cnt [NUM_PROG];

    logic                sel_found;
    logic [ID_W-1:0]     sel_id;
    logic [ID_W:0]       sel_sum;
    logic [NUM_PROG-1:0] sel_oh;
    logic [ID_W-1:0]     next_ptr;
    logic [CNT_W-1:0]    upd_cnt;
    logic [PRE_W-1:0]    upd_pre;

    // Search upward from rr_ptr, wrapping at NUM_PROG-1.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        sel_sum   = '0;
        for (int k = 0; k < NUM_PROG; k++) begin
            sel_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (sel_sum >= NP)
                sel_sum = sel_sum - NP;
            if (!sel_found && strike_req[sel_sum[ID_W-1:0]]) begin
                sel_found = 1'b1;
                sel_id    = sel_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_oh   = NUM_PROG'(1) << sel_id;
        next_ptr = (sel_id == LAST_ID) ? '0 : sel_id + ID_W'(1);
    end

    // Count only on the first flag of each prescale group.
    // PRESCALE is a power of two, so the prescaler wraps naturally.
    always_comb begin
        upd_cnt = cnt[win];
        if (pre[win] == '0 && cnt[win] != CNT_MAX)
            upd_cnt = cnt[win] + CNT_W'(1);
        upd_pre = pre[win] + PRE_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            win         <= '0;
            strike_gnt  <= '0;
            evict_valid <= 1'b0;
            evict_id    <= '0;
            busy        <= 1'b0;
            for (int i = 0; i < NUM_PROG; i++) begin
                pre[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            strike_gnt <= '0;
            unique case (state)
                IDLE: begin
                    if (sel_found) begin
                        win        <= sel_id;
                        strike_gnt <= sel_oh;
                        rr_ptr     <= next_ptr;
                        state      <= UPDATE;
                        busy       <= 1'b1;
                    end
                end
                UPDATE: begin
                    cnt[win] <= upd_cnt;
                    pre[win] <= upd_pre;
                    // A simultaneous clear of the winner cancels eviction.
                    if (!clear_req[win] && upd_cnt >= LIMIT) begin
                        state       <= EVICT;
                        evict_valid <= 1'b1;
                        evict_id    <= win;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                EVICT: begin
                    if (evict_ready) begin
                        cnt[evict_id] <= '0;
                        pre[evict_id] <= '0;
                        evict_valid   <= 1'b0;
                        state         <= IDLE;
                        busy          <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // Clears come last so they override any update this edge.
            for (int i = 0; i < NUM_PROG; i++) begin
                if (clear_req[i]) begin
                    pre[i] <= '0;
                    cnt[i] <= '0;
                end
            end
        end
    end

`ifdef STRIKE_STATUS_EN
    always_comb begin
        strike_count_all = '0;
        for (int i = 0; i < NUM_PROG; i++)
            strike_count_all[i*CNT_W +: CNT_W] = cnt[i];
    end
`endif

endmodule
